// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader streaming bytes into instruction memory and releasing the CPU
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_err
);

    // count must hold DEPTH itself, so it is one bit wider than an address
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_RUN
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [ADDR_W-1:0]  index, index_n;
    logic [7:0]         sum, sum_n;
    logic [7:0]         hi, hi_n;
    logic               imem_we_n;
    logic [ADDR_W-1:0]  imem_addr_n;
    logic [INSTR_W-1:0] imem_wdata_n;
    logic               cpu_reset_n;
    logic               load_done_n;
    logic               load_err_n;
    logic               accept;
    logic               last_word;

    // ready depends only on the registered state so the source never sees a combinational loop
    always_comb begin
        in_ready = (state != S_WRITE) && (state != S_RUN);
    end

    // next-state and next-register computation; every register holds by default
    always_comb begin
        state_n      = state;
        count_n      = count;
        index_n      = index;
        sum_n        = sum;
        hi_n         = hi;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        cpu_reset_n  = cpu_reset;
        load_done_n  = load_done;
        load_err_n   = load_err;
        accept       = in_valid && in_ready;
        last_word    = (CNT_W'(index) == (count - CNT_W'(1)));

        case (state)
            S_IDLE: begin
                if (accept) begin
                    // header 0 stands for a full-memory image
                    count_n    = (in_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(in_data);
                    index_n    = '0;
                    sum_n      = 8'd0;
                    load_err_n = 1'b0;
                    state_n    = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_n    = in_data;
                    sum_n   = sum + in_data;
                    state_n = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    sum_n        = sum + in_data;
                    imem_wdata_n = {hi, in_data};
                    imem_addr_n  = index;
                    imem_we_n    = 1'b1;
                    state_n      = S_WRITE;
                end
            end
            S_WRITE: begin
                // the strobe drops here by default; the index only advances if more words follow
                if (last_word) begin
                    state_n = S_CSUM;
                end else begin
                    index_n = index + ADDR_W'(1);
                    state_n = S_HI;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == sum) begin
                        cpu_reset_n = 1'b0;
                        load_done_n = 1'b1;
                        state_n     = S_RUN;
                    end else begin
                        load_err_n = 1'b1;
                        state_n    = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                // terminal until reset; the CPU owns the memory now
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // state and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            index      <= '0;
            sum        <= 8'd0;
            hi         <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            index      <= index_n;
            sum        <= sum_n;
            hi         <= hi_n;
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            cpu_reset  <= cpu_reset_n;
            load_done  <= load_done_n;
            load_err   <= load_err_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  strm[$];
    logic [23:0] exp_q[$];
    logic        prev_we = 1'b0;
    int          we_count = 0;
    logic [7:0]  last_addr = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int words_of(input logic [7:0] h);
        return (h == 8'd0) ? 256 : int'(h);
    endfunction

    // mod-256 sum of the payload bytes of the current stream
    function automatic logic [7:0] payload_sum();
        logic [7:0] s = 8'd0;
        int n = words_of(strm[0]);
        for (int i = 0; i < 2 * n; i++) s = s + strm[1 + i];
        return s;
    endfunction

    // stream-level model: expected writes are consecutive byte pairs, success iff trailer equals the sum
    task automatic model(output bit ok);
        int n = words_of(strm[0]);
        for (int i = 0; i < n; i++)
            exp_q.push_back({8'(i), strm[1 + 2 * i], strm[2 + 2 * i]});
        ok = (strm[2 * n + 1] == payload_sum());
    endtask

    task automatic build(input int n, input bit good);
        logic [7:0] c;
        strm.delete();
        strm.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) strm.push_back(8'($urandom));
        c = payload_sum();
        if (!good) c = c ^ 8'($urandom_range(1, 255));
        strm.push_back(c);
    endtask

    // compare process: every write must match the model's next expected write
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            check("cpu_reset_vs_done", cpu_reset, !load_done);
            if (load_done) check("ready_in_run", in_ready, 1'b0);
            if (imem_we) begin
                check("ready_in_write", in_ready, 1'b0);
                check("we_single_cycle", prev_we, 1'b0);
                check("write_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", imem_addr, e[23:16]);
                    check("write_data", imem_wdata, e[15:0]);
                end
                we_count++;
                last_addr = imem_addr;
            end
            prev_we = imem_we;
        end
    end

    // offers one byte starting at a negedge; returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] b, inout int cyc);
        logic r;
        int   n = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            r = in_ready;
            @(negedge clk);
            cyc++;
            if (r) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: byte %0h not accepted within 50 cycles", b);
                break;
            end
        end
    endtask

    task automatic send_range(input int first, input int last, input bit gaps, output int cyc);
        cyc = 0;
        for (int i = first; i <= last; i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_byte(strm[i], cyc);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_final(input bit ok);
        check("queue_drained", exp_q.size(), 0);
        check("final_cpu_reset", cpu_reset, !ok);
        check("final_load_done", load_done, ok);
        check("final_load_err", load_err, !ok);
        check("final_in_ready", in_ready, !ok);
    endtask

    task automatic run_stream(input bit gaps, output bit ok, output int cyc);
        model(ok);
        send_range(0, strm.size() - 1, gaps, cyc);
        check_final(ok);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit ok;
        int cyc;
        int wc;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #1;
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 8'd0);
        check("rst_wdata", imem_wdata, 16'd0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done_err", {load_done, load_err}, 2'b00);
        check("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // fixed two-word image with correct checksum
        strm = '{8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hEA};
        check("pin_sum_t1", payload_sum(), 8'hEA);
        model(ok);
        check("pin_first_write", exp_q[0], {8'h00, 16'hA1B2});
        check("pin_ok_t1", ok, 1'b1);
        send_range(0, 5, 1'b0, cyc);
        check_final(1'b1);
        do_reset();

        // bad checksum, then a good load clears the error
        strm = '{8'h01, 8'h12, 8'h34, 8'h00};
        check("pin_sum_t2", payload_sum(), 8'h46);
        run_stream(1'b0, ok, cyc);
        check("pin_ok_t2", ok, 1'b0);
        build(3, 1'b1);
        run_stream(1'b1, ok, cyc);
        do_reset();

        // full 256-word image of 0x01 bytes; sum wraps to 0
        strm.delete();
        strm.push_back(8'h00);
        for (int i = 0; i < 512; i++) strm.push_back(8'h01);
        strm.push_back(8'h00);
        wc = we_count;
        run_stream(1'b0, ok, cyc);
        check("full_write_count", we_count - wc, 256);
        check("full_last_addr", last_addr, 8'hFF);
        do_reset();

        // continuous valid: header + 3 cycles per word + checksum wait = 3N+2 cycles
        build(4, 1'b1);
        run_stream(1'b0, ok, cyc);
        check("burst_cycles", cyc, 14);
        do_reset();

        // asynchronous reset while in LO of word 3
        build(5, 1'b1);
        model(ok);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        send_range(0, 7, 1'b0, cyc);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", imem_we, 1'b0);
        check("mid_rst_addr", imem_addr, 8'd0);
        check("mid_rst_wdata", imem_wdata, 16'd0);
        check("mid_rst_cpu_reset", cpu_reset, 1'b1);
        check("mid_rst_done_err", {load_done, load_err}, 2'b00);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_writes_done", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        build(5, 1'b1);
        run_stream(1'b1, ok, cyc);

        // input in RUN is ignored
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
            check("run_cpu_reset", cpu_reset, 1'b0);
            check("run_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;

        // random loads, with and without gaps, good and bad checksums
        for (int k = 0; k < 20; k++) begin
            if (load_done) do_reset();
            build($urandom_range(1, 8), ($urandom % 4) != 0);
            run_stream(1'($urandom), ok, cyc);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
